echo_delay_buffer: RTL and testbench
====================================

// Module: echo_delay_buffer
// PURPOSE
//  Circular sample store between ADC capture and DAC output in the voice path.
//  Writes each incoming sample at a 13-bit wrapping write pointer. Reads back
//  the sample written `delay` samples earlier. Produces the delayed (or mixed)
//  sample with a valid pulse for the downstream output stage.
// PARAMETERS
//  ADDR_SZ  13  buffer address width; depth = 2**ADDR_SZ samples
//  DATA_SZ  10  sample width, unsigned offset-binary
// PORTS
//  clock      in   1        single clock; all logic on rising edge
//  reset      in   1        synchronous, active-low (0 = reset)
//  data_valid in   1        1-cycle strobe, new sample on data_in
//  data_in    in   DATA_SZ  input sample
//  delay      in   ADDR_SZ  echo delay in samples; sampled on accepted strobe
//  data_out   out  DATA_SZ  output sample; held between valid pulses
//  out_valid  out  1        1-cycle pulse, data_out updated this cycle
//  busy       out  1        high while FSM not IDLE
//  overrun    out  1        sticky; set when strobe arrives while busy
// BEHAVIOUR
//  Reset (reset==0 at rising edge):
//   - state=IDLE, wr_ptr=0, fill_cnt=0, data_out=0, out_valid=0, overrun=0.
//   - RAM contents are not cleared.
//   - Reset mid-operation aborts the sequence; no out_valid is issued.
//  FSM: IDLE -> WRITE -> READ -> OUT -> IDLE.
//   - IDLE : data_valid=1 -> latch data_in, delay; go to WRITE.
//   - WRITE: RAM[wr_ptr] <= sample; wr_ptr <= wr_ptr+1 (wraps 2**ADDR_SZ-1 -> 0);
//            fill_cnt += 1, saturating at 2**ADDR_SZ-1.
//   - READ : rd_addr = (wr_ptr_old - delay) mod 2**ADDR_SZ; sync RAM read,
//            1-cycle latency.
//   - OUT  : data_out <= result; out_valid=1 for exactly this cycle.
//  Latency: out_valid rises 3 cycles after the data_valid cycle. Minimum
//   strobe spacing is 4 cycles.
//  data_valid while busy=1: sample dropped, overrun <= 1. overrun clears only
//   on reset.
//  delay=0: reads the sample just written (pass-through with latency).
//  Priming: while fill_cnt < delay, the delayed sample is forced to 0. This
//   covers start-up and the period after reset.
//  delay changed between strobes takes effect on the next accepted strobe only.
//  Addresses are modulo arithmetic on ADDR_SZ bits; no out-of-range access.
// CONFIGURATION
//  ECHO_MIX_EN defined:
//   - result = (latched_in + delayed) >> 1.
//   - Sum is computed at DATA_SZ+1 bits, so there is no overflow.
//   - While priming, delayed=0, so result = latched_in>>1.
//  ECHO_MIX_EN undefined: result = delayed sample only (pure delay line).
// STRUCTURE
//  Package echo_pkg:
//   - ADDR_SZ/DATA_SZ defaults.
//   - FSM state encoding (IDLE=2'd0, WRITE=2'd1, READ=2'd2, OUT=2'd3).
//  Sub-module echo_sample_ram:
//   - Simple dual-port synchronous RAM: one write port, one read port.
//   - 1-cycle read latency; depth 2**ADDR_SZ x DATA_SZ.
//  Top level holds FSM, pointers, fill counter, priming and mix logic.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles, release
//     -> data_out=0, out_valid=0, busy=0, overrun=0.
//  2. Pass-through: delay=0, data_in=0x155 strobed
//     -> out_valid 3 cycles later with data_out=0x155.
//  3. Delay/priming: delay=4, strobe samples 1..8 every 4 cycles
//     -> outputs 0,0,0,0,1,2,3,4 (mix off).
//  4. Wrap: delay=2, write 8194 samples (value=index[9:0])
//     -> across the 8191->0 pointer wrap, each output = index-2.
//  5. Overrun: strobe, second strobe 1 cycle later
//     -> one out_valid only, overrun=1 stays until reset.
//  6. Mix (ECHO_MIX_EN): delay=1, inputs 0x3FF then 0x001
//     -> outputs 0x1FF then 0x200. Reset asserted in READ -> no out_valid.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared defaults and FSM state encoding for the echo delay buffer.
package echo_pkg;

  localparam int DEF_ADDR_SZ = 13;
  localparam int DEF_DATA_SZ = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/echo_sample_ram.sv
// Simple dual-port sample store: one write port, one read port, 1-cycle read latency.
// Contents are never cleared; reads of unwritten locations are masked upstream.
module echo_sample_ram #(
  parameter int ADDR_SZ = 13,
  parameter int DATA_SZ = 10
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [ADDR_SZ-1:0] wr_addr,
  input  logic [DATA_SZ-1:0] wr_data,
  input  logic [ADDR_SZ-1:0] rd_addr,
  output logic [DATA_SZ-1:0] rd_data
);

  logic [DATA_SZ-1:0] mem [2**ADDR_SZ];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/echo_delay_buffer.sv
// Circular echo delay line; out_valid 3 cycles after an accepted strobe, strobes while busy are dropped and flag overrun.
// Define ECHO_MIX_EN to output (input + delayed) / 2 instead of the delayed sample alone.
module echo_delay_buffer
  import echo_pkg::*;
#(
  parameter int ADDR_SZ = DEF_ADDR_SZ,
  parameter int DATA_SZ = DEF_DATA_SZ
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               data_valid,
  input  logic [DATA_SZ-1:0] data_in,
  input  logic [ADDR_SZ-1:0] delay,
  output logic [DATA_SZ-1:0] data_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [ADDR_SZ-1:0] ADDR_ONE = 1;

  state_t             state_q, state_d;
  logic [ADDR_SZ-1:0] wr_ptr, fill_cnt, delay_q, rd_addr;
  logic [DATA_SZ-1:0] sample_q, rd_data, delayed, result, data_hold;
  logic               prime_q, wr_en;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_valid) state_d = WRITE;
      WRITE:   state_d = READ;
      READ:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      data_hold <= '0;
      overrun   <= 1'b0;
    end else begin
      if (state_q == WRITE) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
        if (fill_cnt != '1) fill_cnt <= fill_cnt + ADDR_ONE;
      end
      if (state_q == OUT) data_hold <= result;
      if (data_valid && state_q != IDLE) overrun <= 1'b1;
    end
  end

  // Priming uses the count before this write: the sample `delay` back exists only if fill_cnt >= delay.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && data_valid) begin
      sample_q <= data_in;
      delay_q  <= delay;
    end
    if (state_q == WRITE) prime_q <= (fill_cnt < delay_q);
  end

  assign wr_en   = (state_q == WRITE);
  // In READ the pointer has already advanced, so the sample just written sits at wr_ptr-1.
  assign rd_addr = wr_ptr - delay_q - ADDR_ONE;

  echo_sample_ram #(
    .ADDR_SZ (ADDR_SZ),
    .DATA_SZ (DATA_SZ)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (sample_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign delayed = prime_q ? '0 : rd_data;

`ifdef ECHO_MIX_EN
  logic [DATA_SZ:0] mix_sum;
  assign mix_sum = {1'b0, sample_q} + {1'b0, delayed};
  assign result  = DATA_SZ'(mix_sum >> 1);
`else
  assign result  = delayed;
`endif

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign data_out  = out_valid ? result : data_hold;

endmodule

// File: tb/tb_echo_delay_buffer.sv
// Directed + randomized bench for echo_delay_buffer; expected samples come from a history-queue model.
module tb_echo_delay_buffer;

  localparam int AW = 13;
  localparam int DW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] delay = '0;
  logic [DW-1:0] data_out;
  logic          out_valid, busy, overrun;

  int total = 0;
  int passes = 0;
  int fails = 0;

  logic [DW-1:0] hist[$];

  echo_delay_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .data_valid (data_valid),
    .data_in    (data_in),
    .delay      (delay),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output = sample written `dly` accepted strobes ago since reset, or 0 if none yet.
  function automatic int model_push(input logic [DW-1:0] d, input int dly);
    int dl;
    hist.push_back(d);
    if (hist.size() > (1 << AW)) void'(hist.pop_front());
    dl = (hist.size() > dly) ? int'(hist[hist.size() - 1 - dly]) : 0;
`ifdef ECHO_MIX_EN
    return (int'(d) + dl) / 2;
`else
    return dl;
`endif
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic send(input int d, input int dly, input string tag);
    int exp;
    int lat;
    data_in    = DW'(d);
    delay      = AW'(dly);
    data_valid = 1'b1;
    exp = model_push(DW'(d), dly);
    @(negedge clock);
    data_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " data"}, 32'(data_out), exp);
    @(negedge clock);
    check({tag, " pulse width"}, 32'(out_valid), 32'd0);
    check({tag, " hold"}, 32'(data_out), exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    hist.delete();
  endtask

  initial begin
    int pulses;
    int seen;
    int exp;
    int g;

    // Reset state
    @(negedge clock);
    do_reset();
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);

    // Pass-through with delay 0
    send(32'h155, 0, "pass");

    // Priming with delay 4 after reset
    do_reset();
    for (int i = 1; i <= 8; i++) send(i, 4, "prime");

    // Write pointer wrap with delay 2
    do_reset();
    for (int i = 0; i < 8194; i++) send(i & 32'h3FF, 2, "wrap");
    // Saturated fill count: the full-depth delay returns the oldest sample
    for (int i = 0; i < 3; i++) send(32'h2A0 + i, (1 << AW) - 1, "maxdly");
    send(32'h0F0, 5000, "middly");

    // Overrun: second strobe one cycle after the first is dropped
    do_reset();
    data_in = DW'(32'h0AA); delay = '0; data_valid = 1'b1;
    exp = model_push(DW'(32'h0AA), 0);
    @(negedge clock);
    data_in = DW'(32'h0BB); data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    pulses = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        pulses++;
        seen = int'(data_out);
      end
      @(negedge clock);
    end
    check("overrun pulse count", pulses, 1);
    check("overrun kept sample", seen, exp);
    check("overrun flag", 32'(overrun), 32'd1);
    send(32'h011, 0, "after overrun");
    check("overrun sticky", 32'(overrun), 32'd1);
    do_reset();
    check("overrun cleared", 32'(overrun), 32'd0);

    // Reset during READ aborts without an output pulse
    data_in = DW'(32'h123); delay = '0; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid) pulses++;
      if (i == 2) reset = 1'b1;
    end
    hist.delete();
    check("abort no out_valid", pulses, 0);
    check("abort busy", 32'(busy), 32'd0);

    // Mix pair (pure delay when mixing is off)
    send(32'h3FF, 1, "mix first");
    send(32'h001, 1, "mix second");

    // Randomized traffic with varying delays and idle gaps
    for (int i = 0; i < 300; i++) begin
      g = int'($urandom_range(0, 2));
      repeat (g) @(negedge clock);
      if ($urandom_range(0, 9) == 0)
        send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 8191)), "rand big");
      else
        send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)), "rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
